// File: rtl/playseq_sessao_controle.sv
// Best-of-N session scheduler above jogo_playseq: starts games, tallies results, paces and decides the series.
// Optional macro SESSAO_TIMEOUT_REPETE_EN: a game's first timeout is replayed instead of counted as a loss.
module playseq_sessao_controle #(
  parameter int N_PARTIDAS = 3,
  parameter int INTERVALO  = 1000,
  parameter int W_INT      = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic       ganhou,
  input  logic       perdeu,
  input  logic       timeout,
  output logic       jogar,
  output logic       sessao_ativa,
  output logic [3:0] vitorias,
  output logic [3:0] derrotas,
  output logic [3:0] partida,
  output logic       sessao_ganha,
  output logic       sessao_perdida,
  output logic [3:0] db_estado
);

  localparam logic [3:0]       M_L       = 4'(N_PARTIDAS / 2 + 1);
  localparam logic [3:0]       N_L       = 4'(N_PARTIDAS);
  localparam logic [W_INT-1:0] FIM_PAUSA = W_INT'(INTERVALO - 1);

  typedef enum logic [2:0] {
    S_OCIOSO    = 3'd0,
    S_DISPARA   = 3'd1,
    S_AGUARDA   = 3'd2,
    S_JOGANDO   = 3'd3,
    S_REGISTRA  = 3'd4,
    S_AVALIA    = 3'd5,
    S_INTERVALO = 3'd6,
    S_FIM       = 3'd7
  } estado_t;

  estado_t          r_estado, w_prox;
  logic [3:0]       r_vit, r_der, r_par;
  logic [W_INT-1:0] r_pausa;
  logic             w_abort, w_limpa, w_inc_vit, w_inc_der, w_avanca, w_pausa_clr, w_pausa_inc;
  logic             w_algum_res;
`ifdef SESSAO_TIMEOUT_REPETE_EN
  logic             r_repetiu;
  logic             w_marca_rep;
`endif

  assign w_algum_res = ganhou | perdeu | timeout;
  assign w_abort     = abortar && (r_estado != S_OCIOSO) && (r_estado != S_FIM);

  // Next-state and datapath control decode; abort overrides every transition.
  always_comb begin
    w_prox      = r_estado;
    w_limpa     = 1'b0;
    w_inc_vit   = 1'b0;
    w_inc_der   = 1'b0;
    w_avanca    = 1'b0;
    w_pausa_clr = 1'b0;
    w_pausa_inc = 1'b0;
`ifdef SESSAO_TIMEOUT_REPETE_EN
    w_marca_rep = 1'b0;
`endif
    if (w_abort) begin
      w_prox = S_OCIOSO;
    end else begin
      case (r_estado)
        S_OCIOSO, S_FIM: begin
          if (iniciar) begin
            w_limpa = 1'b1;
            w_prox  = S_DISPARA;
          end else begin
            w_prox = r_estado;
          end
        end
        S_DISPARA: w_prox = S_AGUARDA;
        // Hold off until the game has dropped the previous result.
        S_AGUARDA: begin
          if (!w_algum_res) begin
            w_prox = S_JOGANDO;
          end else begin
            w_prox = S_AGUARDA;
          end
        end
        S_JOGANDO: begin
          if (w_algum_res) begin
            w_prox = S_REGISTRA;
          end else begin
            w_prox = S_JOGANDO;
          end
        end
        S_REGISTRA: begin
          w_prox = S_AVALIA;
`ifdef SESSAO_TIMEOUT_REPETE_EN
          if (timeout && !ganhou && !r_repetiu) begin
            w_marca_rep = 1'b1;
            w_pausa_clr = 1'b1;
            w_prox      = S_INTERVALO;
          end else
`endif
          if (timeout || perdeu) begin
            w_inc_der = 1'b1;
          end else if (ganhou) begin
            w_inc_vit = 1'b1;
          end else begin
            w_inc_der = 1'b0;
          end
        end
        S_AVALIA: begin
          if ((r_vit >= M_L) || (r_der >= M_L)) begin
            w_prox = S_FIM;
          end else if (r_par == N_L) begin
            w_prox = S_FIM;
          end else begin
            w_avanca    = 1'b1;
            w_pausa_clr = 1'b1;
            w_prox      = S_INTERVALO;
          end
        end
        S_INTERVALO: begin
          w_pausa_inc = 1'b1;
          if (r_pausa == FIM_PAUSA) begin
            w_prox = S_DISPARA;
          end else begin
            w_prox = S_INTERVALO;
          end
        end
        default: w_prox = S_OCIOSO;
      endcase
    end
  end

  // State, tallies, game index and pause counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= S_OCIOSO;
      r_vit    <= 4'd0;
      r_der    <= 4'd0;
      r_par    <= 4'd0;
      r_pausa  <= '0;
    end else begin
      r_estado <= w_prox;
      if (w_limpa) begin
        r_vit   <= 4'd0;
        r_der   <= 4'd0;
        r_par   <= 4'd1;
        r_pausa <= '0;
      end else begin
        if (w_inc_vit && (r_vit != 4'd15)) r_vit <= r_vit + 4'd1;
        if (w_inc_der && (r_der != 4'd15)) r_der <= r_der + 4'd1;
        if (w_avanca && (r_par != 4'd15))  r_par <= r_par + 4'd1;
        if (w_pausa_clr) begin
          r_pausa <= '0;
        end else if (w_pausa_inc) begin
          r_pausa <= r_pausa + W_INT'(1);
        end
      end
    end
  end

`ifdef SESSAO_TIMEOUT_REPETE_EN
  // Per-game replay flag, cleared whenever a new game index begins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_repetiu <= 1'b0;
    end else if (w_limpa || w_avanca) begin
      r_repetiu <= 1'b0;
    end else if (w_marca_rep) begin
      r_repetiu <= 1'b1;
    end
  end
`endif

  assign jogar          = (r_estado == S_DISPARA);
  assign sessao_ativa   = (r_estado != S_OCIOSO) && (r_estado != S_FIM);
  assign vitorias       = r_vit;
  assign derrotas       = r_der;
  assign partida        = r_par;
  assign sessao_ganha   = (r_estado == S_FIM) && (r_vit >= M_L);
  assign sessao_perdida = (r_estado == S_FIM) && (r_vit < M_L);
  assign db_estado      = {1'b0, r_estado};

endmodule
